load_store_sched: RTL
=====================

// Module: load_store_sched
// PURPOSE
//  Scheduler that shares one bounded volume store (0..N units) among NREQ requesters.
//  Each requester asks to load (+1 unit/cycle) or store (-1 unit/cycle).
//  Round-robin picks one eligible requester and grants it a burst of at most QUANTUM units.
//  Sits between the requester ports and the volume datapath; it owns the volume counter and
//  its full/empty flags.
// PARAMETERS
//  N        10000  capacity in units; vol never exceeds N
//  CBITS    14     width of vol; must satisfy 2**CBITS > N
//  NREQ     4      number of requesters (>=2)
//  QUANTUM  16     max units moved per grant (>=1)
//  QBITS    5      width of burst counter; must satisfy 2**QBITS > QUANTUM
// PORTS
//  clk       in   1        clock, all state updates on posedge
//  rst       in   1        synchronous, active-high reset
//  req       in   NREQ     per-requester request, level
//  dir       in   NREQ     per-requester direction: 1=load, 0=store
//  gnt       out  NREQ     one-hot grant (all-zero when idle)
//  vol       out  CBITS    current volume
//  full      out  1        vol == N
//  empty     out  1        vol == 0
//  busy      out  1        burst in progress (state != IDLE)
//  done      out  1        one-cycle pulse in the cycle after a burst ends
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, vol=0, cnt=0, rr_ptr=0, busy=0, done=0; full=0, empty=1.
//  - Eligibility of requester i: req[i] && (dir[i] ? vol!=N : vol!=0).
//  - FSM states IDLE, LOAD, STORE; one burst active at most.
//  - IDLE: scan from rr_ptr upward (mod NREQ) for the first eligible i.
//      * If found: next cycle state=LOAD/STORE per dir[i], gnt=1<<i, cnt=0, busy=1.
//      * Else: stay IDLE.
//      * One-cycle arbitration latency: no volume change in IDLE.
//  - LOAD/STORE, granted requester g, each cycle:
//      * If req[g]=0 or dir[g] disagrees with state: no vol change; end burst.
//      * Otherwise vol +/-1 and cnt+1. End burst when the new vol hits the bound
//        (N for load, 0 for store) or the new cnt == QUANTUM.
//  - End of burst: next cycle state=IDLE, gnt=0, busy=0, done=1 for one cycle,
//    rr_ptr=(g+1) mod NREQ.
//  - Units moved per grant = min(QUANTUM, remaining space/content, cycles req held).
//  - A new grant is possible in the cycle done is high; IDLE lasts >=1 cycle between bursts.
//  - vol never wraps. Saturation is by construction: a bounded requester is ineligible or its
//    burst ends exactly at the bound.
//  - full/empty are combinational from vol.
//  - Simultaneous requests: only the round-robin winner is granted; the others wait.
//    Fairness: each continuously eligible requester is granted within NREQ bursts.
//  - rst mid-burst: everything returns to reset values next cycle; no done pulse.
//  - Required properties:
//      * vol <= N always
//      * $onehot0(gnt)
//      * busy == (gnt != 0)
//      * gnt[g] && !full && dir/req held implies vol increments next cycle
// STRUCTURE
//  - Package load_store_pkg: state_t enum {IDLE, LOAD, STORE}; default values for N, CBITS,
//    QUANTUM.
//  - Sub-module rr_arbiter #(NREQ): inputs elig[NREQ] and rr_ptr; outputs one-hot pick and
//    found. Combinational.
//  - Top holds the FSM, the vol/cnt registers and rr_ptr.
// TESTING
//  1. Reset then req=4'b0001, dir=1, held 20 cycles, N=10000 -> gnt=0001 from cycle 1;
//     vol=16 after 16 load cycles; done pulse; re-grant after 1 IDLE cycle.
//  2. vol=0, req=4'b0010, dir=0 -> never granted; gnt stays 0 and empty stays 1.
//  3. req=4'b1111, all dir=1, held -> grants rotate 0,1,2,3,0; each burst moves 16 units.
//  4. Preload vol=9995, load requester held -> burst of 5; vol=10000, full=1; then ineligible
//     and gnt=0 until a store drains.
//  5. Requester drops req after 3 granted cycles -> vol changes by exactly 3; done next
//     cycle; rr_ptr advances.
//  6. Assert rst in the middle of a load burst -> next cycle gnt=0, vol=0, busy=0, done=0.

Source files
------------

// File: rtl/load_store_pkg.sv
// Shared definitions for the load/store volume scheduler.
// Contents:
//   state_t      scheduler FSM state (IDLE, LOAD, STORE)
//   DEF_*        default parameter values for capacity, widths, requesters, burst quantum
package load_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam int unsigned DEF_N       = 10000;
    localparam int unsigned DEF_CBITS   = 14;
    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_QUANTUM = 16;
    localparam int unsigned DEF_QBITS   = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   elig    in   NREQ    per-requester eligibility
//   rr_ptr  in   PBITS   index searched first; the scan wraps upward mod NREQ
//   pick    out  NREQ    one-hot winner (all-zero when nothing is eligible)
//   found   out  1       some requester is eligible
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PBITS = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [PBITS-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic             found
);

    logic [PBITS:0]   sum;
    logic [PBITS-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            // rr_ptr < NREQ, so one conditional subtract is enough for the wrap
            sum = {1'b0, rr_ptr} + (PBITS+1)'(off);
            if (sum >= (PBITS+1)'(NREQ)) begin
                sum = sum - (PBITS+1)'(NREQ);
            end
            idx = sum[PBITS-1:0];
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_store_sched.sv
// Round-robin scheduler sharing one bounded volume store (0..N units) among NREQ requesters.
// A granted requester moves one unit per cycle (load +1, store -1) for at most QUANTUM cycles.
// Ports:
//   clk    in   1      clock
//   rst    in   1      synchronous active-high reset
//   req    in   NREQ   per-requester request level
//   dir    in   NREQ   per-requester direction, 1 = load, 0 = store
//   gnt    out  NREQ   one-hot grant, all-zero when idle
//   vol    out  CBITS  current volume
//   full   out  1      vol == N
//   empty  out  1      vol == 0
//   busy   out  1      burst in progress
//   done   out  1      one-cycle pulse in the cycle after a burst ends
module load_store_sched
    import load_store_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned CBITS   = DEF_CBITS,
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned QUANTUM = DEF_QUANTUM,
    parameter int unsigned QBITS   = DEF_QBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  dir,
    output logic [NREQ-1:0]  gnt,
    output logic [CBITS-1:0] vol,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      PBITS    = $clog2(NREQ);
    localparam logic [CBITS-1:0] VOL_MAX  = CBITS'(N);
    localparam logic [QBITS-1:0] CNT_MAX  = QBITS'(QUANTUM);
    localparam logic [PBITS-1:0] PTR_LAST = PBITS'(NREQ - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [PBITS-1:0] gidx_q, gidx_d;
    logic [PBITS-1:0] rr_q, rr_d;
    logic [CBITS-1:0] vol_q, vol_d;
    logic [QBITS-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick;
    logic [PBITS-1:0] pick_idx;
    logic             found;
    logic             is_load;
    logic             hold;
    logic             end_burst;
    logic [CBITS-1:0] bound;

    assign full  = (vol_q == VOL_MAX);
    assign empty = (vol_q == '0);

    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i] && (dir[i] ? !full : !empty);
        end
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PBITS (PBITS)
    ) u_arb (
        .elig   (elig),
        .rr_ptr (rr_q),
        .pick   (pick),
        .found  (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PBITS'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        vol_d     = vol_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        is_load   = (state_q == LOAD);
        bound     = is_load ? VOL_MAX : '0;
        hold      = 1'b0;
        end_burst = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = dir[pick_idx] ? LOAD : STORE;
                    gnt_d   = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            LOAD, STORE: begin
                // The bound term is unreachable for a legal grant; it keeps vol from
                // wrapping even if eligibility were ever stale.
                hold = req[gidx_q] && (dir[gidx_q] == is_load) && (vol_q != bound);
                if (hold) begin
                    vol_d     = is_load ? vol_q + 1'b1 : vol_q - 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    end_burst = (vol_d == bound) || (cnt_d == CNT_MAX);
                end else begin
                    end_burst = 1'b1;
                end
                if (end_burst) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    rr_d    = (gidx_q == PTR_LAST) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            vol_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            vol_q   <= vol_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign vol  = vol_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
